// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port.
// ALU results go straight through; multi-cycle results queue in a FIFO with starvation protection.
module regfile_wb_arbiter #(
    parameter int unsigned ADDRESS_WIDTH = 5,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned FIFO_DEPTH    = 2,
    parameter int unsigned STARVE_LIMIT  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [ADDRESS_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0]    alu_wd,
    input  logic                     mdu_valid,
    output logic                     mdu_ready,
    input  logic [ADDRESS_WIDTH-1:0] mdu_rd,
    input  logic [DATA_WIDTH-1:0]    mdu_wd,
    output logic                     WE3,
    output logic [ADDRESS_WIDTH-1:0] AD3,
    output logic [DATA_WIDTH-1:0]    WD3,
    input  logic [ADDRESS_WIDTH-1:0] AD1,
    input  logic [ADDRESS_WIDTH-1:0] AD2,
    output logic                     hazard1,
    output logic                     hazard2,
    output logic                     busy
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_ALU,
        GNT_FIFO
    } grant_e;

    logic [ADDRESS_WIDTH-1:0] fifo_rd_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]    fifo_wd_q [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [STV_W-1:0] starve_q, starve_d;

    logic                     we3_q, we3_d;
    logic [ADDRESS_WIDTH-1:0] ad3_q, ad3_d;
    logic [DATA_WIDTH-1:0]    wd3_q, wd3_d;

    grant_e                   grant;
    logic                     full;
    logic                     nonempty;
    logic                     force_fifo;
    logic                     enq;
    logic                     deq;
    logic [ADDRESS_WIDTH-1:0] win_rd;
    logic [DATA_WIDTH-1:0]    win_wd;
    logic                     pend1;
    logic                     pend2;
    logic [PTR_W-1:0]         scan_idx;

    assign full       = (count_q == CNT_W'(FIFO_DEPTH));
    assign nonempty   = (count_q != '0);
    assign force_fifo = nonempty && (starve_q == STV_W'(STARVE_LIMIT));

    always_comb begin
        grant     = GNT_NONE;
        alu_ready = rst_n;
        if (force_fifo) begin
            grant     = GNT_FIFO;
            alu_ready = 1'b0;
        end else if (alu_valid) begin
            grant = GNT_ALU;
        end else if (nonempty) begin
            grant = GNT_FIFO;
        end
    end

    // No full-bypass: a dequeue in the same cycle does not reopen mdu_ready.
    assign mdu_ready = rst_n && !full;
    assign enq       = mdu_valid && mdu_ready;
    assign deq       = (grant == GNT_FIFO);

    always_comb begin
        wr_ptr_d = enq ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = deq ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({enq, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (deq || !nonempty) begin
            starve_d = '0;
        end else if (grant == GNT_ALU && starve_q != STV_W'(STARVE_LIMIT)) begin
            starve_d = starve_q + STV_W'(1);
        end
    end

    always_comb begin
        win_rd = alu_rd;
        win_wd = alu_wd;
        if (grant == GNT_FIFO) begin
            win_rd = fifo_rd_q[rd_ptr_q];
            win_wd = fifo_wd_q[rd_ptr_q];
        end
    end

    // A grant to x0 still updates AD3/WD3 but never raises WE3.
    always_comb begin
        we3_d = 1'b0;
        ad3_d = ad3_q;
        wd3_d = wd3_q;
        if (grant != GNT_NONE) begin
            we3_d = (win_rd != '0);
            ad3_d = win_rd;
            wd3_d = win_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            we3_q    <= 1'b0;
            ad3_q    <= '0;
            wd3_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            we3_q    <= we3_d;
            ad3_q    <= ad3_d;
            wd3_q    <= wd3_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_rd_q[wr_ptr_q] <= mdu_rd;
            fifo_wd_q[wr_ptr_q] <= mdu_wd;
        end
    end

    // Only slots between the read pointer and read pointer + count hold live entries.
    always_comb begin
        pend1    = 1'b0;
        pend2    = 1'b0;
        scan_idx = '0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            scan_idx = rd_ptr_q + PTR_W'(i);
            if (CNT_W'(i) < count_q) begin
                if (fifo_rd_q[scan_idx] == AD1) pend1 = 1'b1;
                if (fifo_rd_q[scan_idx] == AD2) pend2 = 1'b1;
            end
        end
    end

    assign hazard1 = (AD1 != '0) && (pend1 || (we3_q && ad3_q == AD1));
    assign hazard2 = (AD2 != '0) && (pend2 || (we3_q && ad3_q == AD2));

    assign busy = nonempty;
    assign WE3  = we3_q;
    assign AD3  = ad3_q;
    assign WD3  = wd3_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, ALU path, starvation forcing,
// FIFO drain, hazard flags and mid-operation reset.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_wd;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_wd;
    logic        WE3;
    logic [4:0]  AD3;
    logic [31:0] WD3;
    logic [4:0]  AD1;
    logic [4:0]  AD2;
    logic        hazard1;
    logic        hazard2;
    logic        busy;

    int tests  = 0;
    int failed = 0;

    regfile_wb_arbiter #(
        .ADDRESS_WIDTH(5),
        .DATA_WIDTH   (32),
        .FIFO_DEPTH   (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .alu_valid(alu_valid),
        .alu_ready(alu_ready),
        .alu_rd   (alu_rd),
        .alu_wd   (alu_wd),
        .mdu_valid(mdu_valid),
        .mdu_ready(mdu_ready),
        .mdu_rd   (mdu_rd),
        .mdu_wd   (mdu_wd),
        .WE3      (WE3),
        .AD3      (AD3),
        .WD3      (WD3),
        .AD1      (AD1),
        .AD2      (AD2),
        .hazard1  (hazard1),
        .hazard2  (hazard2),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held for two edges with an ALU request pending
        rst_n = 1'b0; alu_valid = 1'b1; alu_rd = 5'd3; alu_wd = 32'h33;
        mdu_valid = 1'b0; mdu_rd = '0; mdu_wd = '0; AD1 = 5'd3; AD2 = 5'd0;
        #1;
        chk("rst_alu_ready_low", alu_ready, 0);
        chk("rst_mdu_ready_low", mdu_ready, 0);
        tick(); tick();
        chk("rst_we3", WE3, 0);
        chk("rst_ad3", AD3, 0);
        chk("rst_wd3", WD3, 0);
        chk("rst_alu_ready", alu_ready, 0);
        chk("rst_mdu_ready", mdu_ready, 0);
        chk("rst_hazard1", hazard1, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1; alu_valid = 1'b0;
        #1;
        chk("rel_mdu_ready", mdu_ready, 1);
        chk("rel_alu_ready", alu_ready, 1);
        chk("rel_busy", busy, 0);

        // ALU write, then a write to x0
        alu_valid = 1'b1; alu_rd = 5'd5; alu_wd = 32'hDEADBEEF; AD1 = 5'd5;
        tick();
        chk("alu_we3", WE3, 1);
        chk("alu_ad3", AD3, 5);
        chk("alu_wd3", WD3, 32'hDEADBEEF);
        chk("alu_hazard_we3", hazard1, 1);
        alu_rd = 5'd0; alu_wd = 32'h1234;
        tick();
        chk("x0_we3", WE3, 0);
        chk("x0_wd3", WD3, 32'h1234);
        chk("x0_hazard", hazard1, 0);

        // Starvation: fill FIFO with rd7, rd8 while ALU stays valid
        alu_rd = 5'd20; alu_wd = 32'hA0; mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_wd = 32'h11;
        #1;
        chk("stv_mdu_ready0", mdu_ready, 1);
        tick();
        chk("stv_ad3_20", AD3, 20);
        chk("stv_busy", busy, 1);
        alu_rd = 5'd21; alu_wd = 32'hA1; mdu_rd = 5'd8; mdu_wd = 32'h22;
        #1;
        chk("stv_mdu_ready1", mdu_ready, 1);
        tick();
        chk("stv_ad3_21", AD3, 21);
        mdu_valid = 1'b0; AD1 = 5'd7; AD2 = 5'd0;
        #1;
        chk("stv_full_mdu_ready", mdu_ready, 0);
        chk("hz_fifo_h1", hazard1, 1);
        chk("hz_fifo_h2", hazard2, 0);
        for (int k = 22; k <= 24; k++) begin
            alu_rd = 5'(k); alu_wd = 32'(k - 20) + 32'hA0;
            #1;
            chk("stv_alu_ready", alu_ready, 1);
            tick();
            chk("stv_we3", WE3, 1);
            chk("stv_ad3", AD3, 32'(k));
        end
        alu_rd = 5'd25; alu_wd = 32'hA5;
        #1;
        chk("force1_alu_ready", alu_ready, 0);
        tick();
        chk("force1_we3", WE3, 1);
        chk("force1_ad3", AD3, 7);
        chk("force1_wd3", WD3, 32'h11);
        chk("force1_mdu_ready", mdu_ready, 1);
        chk("hz_we3_h1", hazard1, 1);
        AD2 = 5'd8;
        #1;
        chk("hz_fifo8_h2", hazard2, 1);
        chk("post_force_alu_ready", alu_ready, 1);
        tick();
        chk("stv2_ad3_25", AD3, 25);
        chk("stv2_wd3_25", WD3, 32'hA5);
        chk("hz_after_h1", hazard1, 0);
        for (int k = 26; k <= 28; k++) begin
            alu_rd = 5'(k); alu_wd = 32'(k - 20) + 32'hA0;
            tick();
            chk("stv2_ad3", AD3, 32'(k));
            chk("stv2_wd3", WD3, 32'(k - 20) + 32'hA0);
        end
        alu_rd = 5'd29; alu_wd = 32'hA9;
        #1;
        chk("force2_alu_ready", alu_ready, 0);
        tick();
        chk("force2_ad3", AD3, 8);
        chk("force2_wd3", WD3, 32'h22);
        chk("force2_busy", busy, 0);
        chk("force2_mdu_ready", mdu_ready, 1);
        chk("force2_h2", hazard2, 1);

        // Drain: fill with rd9, rd10 alongside ALU traffic, then let ALU idle
        alu_rd = 5'd1; alu_wd = 32'h101; mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_wd = 32'h99;
        AD1 = 5'd10; AD2 = 5'd0;
        tick();
        chk("drn_ad3_1", AD3, 1);
        alu_rd = 5'd2; alu_wd = 32'h102; mdu_rd = 5'd10; mdu_wd = 32'hAA;
        tick();
        chk("drn_ad3_2", AD3, 2);
        alu_valid = 1'b0; mdu_valid = 1'b0;
        #1;
        chk("drn_full_mdu_ready", mdu_ready, 0);
        chk("drn_busy_full", busy, 1);
        chk("drn_h1_fifo", hazard1, 1);
        tick();
        chk("drn_we3_9", WE3, 1);
        chk("drn_ad3_9", AD3, 9);
        chk("drn_wd3_9", WD3, 32'h99);
        chk("drn_mdu_ready", mdu_ready, 1);
        tick();
        chk("drn_we3_10", WE3, 1);
        chk("drn_ad3_10", AD3, 10);
        chk("drn_wd3_10", WD3, 32'hAA);
        chk("drn_busy_empty", busy, 0);
        chk("drn_h1_we3", hazard1, 1);
        tick();
        chk("drn_idle_we3", WE3, 0);
        chk("drn_idle_ad3_hold", AD3, 10);
        chk("drn_idle_h1", hazard1, 0);

        // Mid-operation reset with a full FIFO and ALU pending
        alu_valid = 1'b1; alu_rd = 5'd3; alu_wd = 32'h103;
        mdu_valid = 1'b1; mdu_rd = 5'd12; mdu_wd = 32'hCC;
        tick();
        alu_rd = 5'd4; alu_wd = 32'h104; mdu_rd = 5'd13; mdu_wd = 32'hDD;
        tick();
        chk("mid_busy", busy, 1);
        chk("mid_full", mdu_ready, 0);
        mdu_valid = 1'b0; alu_rd = 5'd6; alu_wd = 32'h106; AD1 = 5'd12; AD2 = 5'd13;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_alu_ready", alu_ready, 0);
        chk("mid_rst_mdu_ready", mdu_ready, 0);
        chk("mid_pre_h1", hazard1, 1);
        tick();
        chk("mid_we3", WE3, 0);
        chk("mid_ad3", AD3, 0);
        chk("mid_wd3", WD3, 0);
        chk("mid_busy_clr", busy, 0);
        chk("mid_h1", hazard1, 0);
        chk("mid_h2", hazard2, 0);
        rst_n = 1'b1; alu_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("post_rst_we3", WE3, 0);
            chk("post_rst_busy", busy, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
